// File: rtl/awgn_chk_pkg.sv
// Shared types, default parameter constants and lane helper for the AWGN
// stream checker. Optional build macro used by the checker: CHK_TOL_EN.
package awgn_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } chk_state_t;

  localparam int DEF_W       = 16;
  localparam int DEF_NCH     = 2;
  localparam int DEF_DEPTH   = 16;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 1024;
  localparam int DEF_TOL     = 1;

  // Widest lane and widest packed vector the lane helper can handle.
  localparam int LANE_MAX_W  = 64;
  localparam int VEC_MAX_W   = 1024;

  // Extract lane k of width w from a packed vector (lane k at [k*w +: w]).
  function automatic logic [LANE_MAX_W-1:0] lane(input logic [VEC_MAX_W-1:0] vec,
                                                 input int unsigned k,
                                                 input int unsigned w);
    logic [LANE_MAX_W-1:0] mask;
    mask = '1;
    mask = mask >> (LANE_MAX_W - w);
    return LANE_MAX_W'(vec >> (k * w)) & mask;
  endfunction

endpackage

// File: rtl/awgn_chk_fifo.sv
// Expected-vector FIFO: DEPTH entries (power of 2), wrap-bit pointers for
// full/empty, synchronous clear for run restarts. The head entry is read
// combinationally so the checker can compare on the same cycle it pops.
module awgn_chk_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic [DW-1:0] mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_reg[AW-1:0]];

  // Storage array; no reset so it maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wdata;
    end
  end

  // Read/write pointers; the extra top bit separates full from empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/awgn_stream_checker.sv
// Self-checking comparator for AWGN generator streams. Expected vectors are
// queued in a FIFO and compared lane by lane against DUT samples arriving at
// any latency. Build macro CHK_TOL_EN switches lanes from exact equality to a
// signed |dut-exp| <= TOL match.
module awgn_stream_checker
  import awgn_chk_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int NCH     = DEF_NCH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
`ifdef CHK_TOL_EN
  ,
  parameter int TOL     = DEF_TOL
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             exp_valid,
  output logic             exp_ready,
  input  logic [NCH*W-1:0] exp_data,
  input  logic             dut_valid,
  input  logic [NCH*W-1:0] dut_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] mism_cnt,
  output logic [NCH-1:0]   ch_err,
  output logic [CNT_W-1:0] first_idx,
  output logic             first_vld,
  output logic             orphan_err,
  output logic             timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  chk_state_t       state_reg, state_next;
  logic [CNT_W-1:0] num_vec_reg, push_cnt_reg, cmp_cnt_reg;
  logic [CNT_W-1:0] match_cnt_reg, mism_cnt_reg, first_idx_reg;
  logic [NCH-1:0]   ch_err_reg;
  logic             first_vld_reg, orphan_reg, timeout_reg;
  logic [TW-1:0]    tmo_reg;

  logic             run_start, push, accept, pop, orphan_hit;
  logic             outstanding, tmo_hit;
  logic             fifo_full, fifo_empty;
  logic [NCH*W-1:0] head_data;
  logic [NCH-1:0]   lane_bad;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign run_start   = start && (state_reg != ST_RUN);
  assign exp_ready   = (state_reg == ST_RUN) && !fifo_full && (push_cnt_reg < num_vec_reg);
  assign push        = exp_valid && exp_ready;
  assign accept      = dut_valid && (state_reg == ST_RUN);
  assign pop         = accept && !fifo_empty;
  assign orphan_hit  = accept && fifo_empty;
  assign outstanding = push_cnt_reg > cmp_cnt_reg;
  assign tmo_hit     = (state_reg == ST_RUN) && outstanding && !dut_valid &&
                       (tmo_reg == TW'(TIMEOUT - 1));

  awgn_chk_fifo #(
    .DW    (NCH * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (run_start),
    .push  (push),
    .wdata (exp_data),
    .pop   (pop),
    .rdata (head_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Per-lane verdict between the FIFO head and the incoming DUT sample.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
    logic [W-1:0] e_lane, d_lane;
    assign e_lane = W'(lane(VEC_MAX_W'(head_data), gi, W));
    assign d_lane = W'(lane(VEC_MAX_W'(dut_data), gi, W));
`ifdef CHK_TOL_EN
    // Sign-extended difference in W+1 bits cannot overflow.
    logic [W:0] diff, mag;
    assign diff         = {d_lane[W-1], d_lane} - {e_lane[W-1], e_lane};
    assign mag          = diff[W] ? (~diff + 1'b1) : diff;
    assign lane_bad[gi] = (mag > (W+1)'(TOL));
`else
    assign lane_bad[gi] = (d_lane != e_lane);
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state: a zero-length run goes straight to DONE; RUN ends on the
  // final registered compare or on idle timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) state_next = (num_vec == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if ((cmp_cnt_reg == num_vec_reg) || tmo_hit) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Run bookkeeping: counters, sticky flags and the idle timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_vec_reg   <= '0;
      push_cnt_reg  <= '0;
      cmp_cnt_reg   <= '0;
      match_cnt_reg <= '0;
      mism_cnt_reg  <= '0;
      first_idx_reg <= '0;
      first_vld_reg <= 1'b0;
      ch_err_reg    <= '0;
      orphan_reg    <= 1'b0;
      timeout_reg   <= 1'b0;
      tmo_reg       <= '0;
    end else if (run_start) begin
      num_vec_reg   <= num_vec;
      push_cnt_reg  <= '0;
      cmp_cnt_reg   <= '0;
      match_cnt_reg <= '0;
      mism_cnt_reg  <= '0;
      first_idx_reg <= '0;
      first_vld_reg <= 1'b0;
      ch_err_reg    <= '0;
      orphan_reg    <= 1'b0;
      timeout_reg   <= 1'b0;
      tmo_reg       <= '0;
    end else if (state_reg == ST_RUN) begin
      if (push) push_cnt_reg <= sat_inc(push_cnt_reg);
      if (pop) begin
        cmp_cnt_reg <= sat_inc(cmp_cnt_reg);
        if (|lane_bad) begin
          mism_cnt_reg <= sat_inc(mism_cnt_reg);
          ch_err_reg   <= ch_err_reg | lane_bad;
          if (!first_vld_reg) begin
            first_idx_reg <= cmp_cnt_reg;
            first_vld_reg <= 1'b1;
          end
        end else begin
          match_cnt_reg <= sat_inc(match_cnt_reg);
        end
      end
      if (orphan_hit) orphan_reg <= 1'b1;
      if (dut_valid)        tmo_reg <= '0;
      else if (outstanding) tmo_reg <= tmo_reg + 1'b1;
      if (tmo_hit) timeout_reg <= 1'b1;
    end
  end

  assign busy        = (state_reg == ST_RUN);
  assign done        = (state_reg == ST_DONE);
  assign pass        = done && (mism_cnt_reg == '0) && !orphan_reg && !timeout_reg &&
                       (match_cnt_reg == num_vec_reg);
  assign match_cnt   = match_cnt_reg;
  assign mism_cnt    = mism_cnt_reg;
  assign ch_err      = ch_err_reg;
  assign first_idx   = first_idx_reg;
  assign first_vld   = first_vld_reg;
  assign orphan_err  = orphan_reg;
  assign timeout_err = timeout_reg;

endmodule

// File: tb/tb_awgn_stream_checker.sv
// Directed bench for awgn_stream_checker (W=16, NCH=2, DEPTH=16, TIMEOUT=1024).
// Build with CHK_TOL_EN defined to exercise the tolerance variant (TOL=4).
module tb_awgn_stream_checker;

  localparam int W     = 16;
  localparam int NCH   = 2;
  localparam int CNT_W = 16;
  localparam int BIG   = 1 << 30;
`ifdef CHK_TOL_EN
  localparam bit TOL_BUILD = 1'b1;
`else
  localparam bit TOL_BUILD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset, start, exp_valid, exp_ready, dut_valid;
  logic [CNT_W-1:0] num_vec;
  logic [NCH*W-1:0] exp_data, dut_data;
  logic             busy, done, pass, first_vld, orphan_err, timeout_err;
  logic [CNT_W-1:0] match_cnt, mism_cnt, first_idx;
  logic [NCH-1:0]   ch_err;
  logic [56:0]      all_out;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign all_out = {exp_ready, busy, done, pass, match_cnt, mism_cnt, ch_err,
                    first_idx, first_vld, orphan_err, timeout_err};

  awgn_stream_checker #(
    .W       (W),
    .NCH     (NCH),
    .DEPTH   (16),
    .CNT_W   (CNT_W),
    .TIMEOUT (1024)
`ifdef CHK_TOL_EN
    ,
    .TOL     (4)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_vec     (num_vec),
    .exp_valid   (exp_valid),
    .exp_ready   (exp_ready),
    .exp_data    (exp_data),
    .dut_valid   (dut_valid),
    .dut_data    (dut_data),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .match_cnt   (match_cnt),
    .mism_cnt    (mism_cnt),
    .ch_err      (ch_err),
    .first_idx   (first_idx),
    .first_vld   (first_vld),
    .orphan_err  (orphan_err),
    .timeout_err (timeout_err)
  );

  // Golden vector i: lane0 = 0x1000 + 7i, lane1 = 0xA5A5 ^ 13i.
  function automatic logic [31:0] vec_of(input int i);
    logic [15:0] a, b;
    a = 16'h1000 + 16'(i * 7);
    b = 16'hA5A5 ^ 16'(i * 13);
    return {b, a};
  endfunction

  task automatic do_start(input int n);
    @(negedge clk);
    start   = 1'b1;
    num_vec = CNT_W'(n);
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Streams n expected vectors; the modelled DUT echoes each one lat cycles
  // after it was accepted, optionally corrupting one, stalling, or aborting.
  task automatic run_stream(input int n, input int lat, input int bad_idx,
                            input int stall_after, input int abort_at, input int budget,
                            output bit finished, output int ready_low,
                            output int occ_min, output int occ_max,
                            output int last_dut, output int end_cyc);
    int pushed, sent, occ;
    int sched[$];
    pushed = 0; sent = 0; finished = 1'b0; ready_low = 0;
    occ_min = BIG; occ_max = -1; last_dut = -1; end_cyc = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin
        finished = 1'b1;
        end_cyc  = cyc;
        break;
      end
      if (abort_at >= 0 && sent == abort_at) break;
      occ = pushed - sent;
      if (sched.size() > 0 && sched[0] <= cyc && sent < stall_after) begin
        dut_valid = 1'b1;
        dut_data  = vec_of(sent);
        if (sent == bad_idx) dut_data[31:16] = dut_data[31:16] + 16'd4;
        void'(sched.pop_front());
        sent++;
        last_dut = cyc;
      end else begin
        dut_valid = 1'b0;
      end
      if (pushed < n) begin
        exp_valid = 1'b1;
        exp_data  = vec_of(pushed);
        if (exp_ready) begin
          sched.push_back(cyc + lat);
          pushed++;
        end else if (busy) begin
          ready_low++;
          if (occ < occ_min) occ_min = occ;
          if (occ > occ_max) occ_max = occ;
        end
      end else begin
        exp_valid = 1'b0;
      end
    end
    exp_valid = 1'b0;
    dut_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; num_vec = '0;
    exp_valid = 1'b0; exp_data = '0; dut_valid = 1'b0; dut_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (all_out !== 57'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, expected 0", all_out);
    end
    $display("reset: outputs=%h", all_out);
  endtask

  task automatic test_num_vec_zero();
    do_start(0);
    vectors++;
    if (done !== 1'b1) begin miscompares++; $display("FAIL zero_done: got %b, expected 1", done); end
    vectors++;
    if (pass !== 1'b1) begin miscompares++; $display("FAIL zero_pass: got %b, expected 1", pass); end
    $display("run zero: done=%b pass=%b", done, pass);
  endtask

  task automatic test_clean();
    bit fin; int rl, omin, omax, ld, ec;
    do_start(100);
    run_stream(100, 5, -1, BIG, -1, 2000, fin, rl, omin, omax, ld, ec);
    vectors++;
    if (fin !== 1'b1) begin miscompares++; $display("FAIL clean_done: got %b, expected 1", fin); end
    vectors++;
    if (match_cnt !== 16'd100) begin miscompares++; $display("FAIL clean_match: got %0d, expected 100", match_cnt); end
    vectors++;
    if (mism_cnt !== 16'd0) begin miscompares++; $display("FAIL clean_mism: got %0d, expected 0", mism_cnt); end
    vectors++;
    if (pass !== 1'b1) begin miscompares++; $display("FAIL clean_pass: got %b, expected 1", pass); end
    $display("run clean: match=%0d mism=%0d pass=%b", match_cnt, mism_cnt, pass);
  endtask

  task automatic test_corrupt();
    bit fin; int rl, omin, omax, ld, ec;
    do_start(50);
    run_stream(50, 5, 37, BIG, -1, 2000, fin, rl, omin, omax, ld, ec);
    vectors++;
    if (fin !== 1'b1) begin miscompares++; $display("FAIL corrupt_done: got %b, expected 1", fin); end
    vectors++;
    if (mism_cnt !== (TOL_BUILD ? 16'd0 : 16'd1)) begin
      miscompares++; $display("FAIL corrupt_mism: got %0d, expected %0d", mism_cnt, TOL_BUILD ? 0 : 1);
    end
    vectors++;
    if (match_cnt !== (TOL_BUILD ? 16'd50 : 16'd49)) begin
      miscompares++; $display("FAIL corrupt_match: got %0d, expected %0d", match_cnt, TOL_BUILD ? 50 : 49);
    end
    vectors++;
    if (ch_err !== (TOL_BUILD ? 2'b00 : 2'b10)) begin
      miscompares++; $display("FAIL corrupt_ch_err: got %b, expected %b", ch_err, TOL_BUILD ? 2'b00 : 2'b10);
    end
    vectors++;
    if (first_vld !== !TOL_BUILD) begin
      miscompares++; $display("FAIL corrupt_first_vld: got %b, expected %b", first_vld, !TOL_BUILD);
    end
    vectors++;
    if (first_idx !== (TOL_BUILD ? 16'd0 : 16'd37)) begin
      miscompares++; $display("FAIL corrupt_first_idx: got %0d, expected %0d", first_idx, TOL_BUILD ? 0 : 37);
    end
    vectors++;
    if (pass !== TOL_BUILD) begin
      miscompares++; $display("FAIL corrupt_pass: got %b, expected %b", pass, TOL_BUILD);
    end
    $display("run corrupt: match=%0d mism=%0d ch_err=%b first_idx=%0d pass=%b",
             match_cnt, mism_cnt, ch_err, first_idx, pass);
  endtask

  task automatic test_restart();
    bit fin; int rl, omin, omax, ld, ec;
    do_start(30);
    vectors++;
    if ({busy, match_cnt, mism_cnt, ch_err, first_vld} !== {1'b1, 16'd0, 16'd0, 2'b00, 1'b0}) begin
      miscompares++;
      $display("FAIL restart_clear: got busy=%b match=%0d mism=%0d ch_err=%b first_vld=%b, expected 1 0 0 00 0",
               busy, match_cnt, mism_cnt, ch_err, first_vld);
    end
    run_stream(30, 3, -1, BIG, -1, 1000, fin, rl, omin, omax, ld, ec);
    vectors++;
    if ({fin, pass, match_cnt} !== {1'b1, 1'b1, 16'd30}) begin
      miscompares++;
      $display("FAIL restart_pass: got done=%b pass=%b match=%0d, expected 1 1 30", fin, pass, match_cnt);
    end
    $display("run restart: match=%0d pass=%b", match_cnt, pass);
  endtask

  task automatic test_fifo_full();
    bit fin; int rl, omin, omax, ld, ec;
    do_start(100);
    run_stream(100, 40, -1, BIG, -1, 3000, fin, rl, omin, omax, ld, ec);
    vectors++;
    if (rl <= 0) begin miscompares++; $display("FAIL full_stall_seen: got %0d stalled cycles, expected >0", rl); end
    vectors++;
    if (omin !== 16 || omax !== 16) begin
      miscompares++; $display("FAIL full_occupancy: got min=%0d max=%0d, expected 16 16", omin, omax);
    end
    vectors++;
    if ({fin, pass, match_cnt} !== {1'b1, 1'b1, 16'd100}) begin
      miscompares++;
      $display("FAIL full_result: got done=%b pass=%b match=%0d, expected 1 1 100", fin, pass, match_cnt);
    end
    $display("run fifo_full: stalled=%0d occ=%0d..%0d match=%0d pass=%b", rl, omin, omax, match_cnt, pass);
  endtask

  task automatic test_orphan();
    int waited;
    do_start(2);
    // Sample with an empty FIFO while vector 0 is pushed the same cycle.
    exp_valid = 1'b1; exp_data = vec_of(0);
    dut_valid = 1'b1; dut_data = vec_of(0);
    @(negedge clk);
    vectors++;
    if (orphan_err !== 1'b1) begin miscompares++; $display("FAIL orphan_flag: got %b, expected 1", orphan_err); end
    vectors++;
    if (match_cnt !== 16'd0) begin miscompares++; $display("FAIL orphan_no_bypass: got %0d, expected 0", match_cnt); end
    exp_data = vec_of(1);
    dut_data = vec_of(0);
    @(negedge clk);
    vectors++;
    if (match_cnt !== 16'd1) begin miscompares++; $display("FAIL orphan_first_cmp: got %0d, expected 1", match_cnt); end
    exp_valid = 1'b0;
    dut_data  = vec_of(1);
    @(negedge clk);
    dut_valid = 1'b0;
    waited = 0;
    while (!done && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if ({done, pass, match_cnt, mism_cnt} !== {1'b1, 1'b0, 16'd2, 16'd0}) begin
      miscompares++;
      $display("FAIL orphan_result: got done=%b pass=%b match=%0d mism=%0d, expected 1 0 2 0",
               done, pass, match_cnt, mism_cnt);
    end
    $display("run orphan: orphan_err=%b match=%0d pass=%b", orphan_err, match_cnt, pass);
  endtask

  task automatic test_timeout();
    bit fin; int rl, omin, omax, ld, ec, edges;
    do_start(20);
    run_stream(20, 5, -1, 10, -1, 2000, fin, rl, omin, omax, ld, ec);
    // Flag first visible in cycle ec means it was registered at the edge ending ec-1.
    edges = ec - 1 - ld;
    vectors++;
    if ({fin, timeout_err, pass, match_cnt} !== {1'b1, 1'b1, 1'b0, 16'd10}) begin
      miscompares++;
      $display("FAIL timeout_result: got done=%b timeout_err=%b pass=%b match=%0d, expected 1 1 0 10",
               fin, timeout_err, pass, match_cnt);
    end
    vectors++;
    if (edges !== 1024) begin
      miscompares++; $display("FAIL timeout_delay: got %0d cycles, expected 1024", edges);
    end
    $display("run timeout: edges_after_last_sample=%0d timeout_err=%b done=%b", edges, timeout_err, done);
  endtask

  task automatic test_reset_midrun();
    bit fin; int rl, omin, omax, ld, ec;
    do_start(100);
    run_stream(100, 5, -1, BIG, 50, 2000, fin, rl, omin, omax, ld, ec);
    vectors++;
    if ({busy, match_cnt} !== {1'b1, 16'd50}) begin
      miscompares++; $display("FAIL midrun_progress: got busy=%b match=%0d, expected 1 50", busy, match_cnt);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (all_out !== 57'd0) begin
      miscompares++; $display("FAIL midrun_reset: got %h, expected 0", all_out);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++; $display("FAIL midrun_idle: got busy=%b done=%b, expected 0 0", busy, done);
    end
    $display("run reset_midrun: outputs after reset=%h", all_out);
  endtask

  initial begin
    test_reset();
    test_num_vec_zero();
    test_clean();
    test_corrupt();
    test_restart();
    test_fifo_full();
    test_orphan();
    test_timeout();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion after 50000 cycles, expected $finish");
    $fatal(1, "watchdog expired");
  end

endmodule
